score_accumulator: RTL and testbench
====================================

Name: score_accumulator

Overview:
Parametrised multi-channel score accumulator. It generalises the single 8-bit add-on-LD accumulator to CHANNELS independent scores of WIDTH bits. Each channel has a one-entry request buffer, and one shared adder is granted round-robin. The block supports saturating or wrapping arithmetic, sticky overflow and drop flags, and a registered leader index for the display and game-over logic.

Parameters:
WIDTH, 8, bit width of each score and each addend.
CHANNELS, 2, number of independent scores (players); must be >= 2.
SATURATE, 1, 1 = clamp at 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
CLR  in  1  reset; asynchronous, active-high.
LD  in  CHANNELS  per-channel add request.
D  in  CHANNELS*WIDTH  per-channel addend; channel i is D[i*WIDTH +: WIDTH].
CLR_CH  in  CHANNELS  per-channel synchronous clear.
RDY  out  CHANNELS  channel i can accept LD; combinational, equals !pend_v[i].
Q  out  CHANNELS*WIDTH  per-channel score; registered.
OVF  out  CHANNELS  sticky overflow per channel.
DROP  out  CHANNELS  sticky flag: LD[i] was asserted while RDY[i]=0.
LEAD  out  max(1,$clog2(CHANNELS))  index of the highest score; registered.

Behaviour:
- Reset (CLR=1, async):
  - Q, OVF, DROP, LEAD, pend_v and pend all go to 0; RDY is therefore all 1s.
  - Round-robin pointer goes to CHANNELS-1, so channel 0 has first priority.
  - CLR mid-operation discards all pending requests.
- Capture:
  - Condition: rising edge with LD[i]=1 and RDY[i]=1.
  - Action: pend[i]<=D slice, pend_v[i]<=1.
- Drop:
  - Condition: LD[i]=1 with RDY[i]=0.
  - Action: the request is ignored and DROP[i]<=1.
- Arbitration:
  - Each cycle, grant at most one channel with pend_v=1.
  - Search order is circular, starting at pointer+1.
  - On a grant, pointer<=granted index; with no grant, the pointer holds.
- Commit (granted channel g):
  - sum = Q[g] + pend[g], computed WIDTH+1 bits wide.
  - If sum[WIDTH]=1: SATURATE=1 gives Q[g]<=all ones; SATURATE=0 gives Q[g]<=sum[WIDTH-1:0]. In both modes OVF[g]<=1.
  - Otherwise Q[g]<=sum[WIDTH-1:0].
  - pend_v[g]<=0 on the same edge.
- Latency:
  - Capture at edge k; earliest commit at edge k+1.
  - Worst case is commit at edge k+CHANNELS.
  - RDY[i] returns high the cycle after commit.
  - Peak throughput is one request per channel every 2 cycles; the aggregate is one commit per cycle.
- CLR_CH[i]=1 (sync):
  - Q[i], OVF[i], DROP[i] and pend_v[i] go to 0.
  - Takes precedence over a commit and a capture for channel i on the same edge.
  - The arbiter must not grant a channel whose CLR_CH is high.
  - A grant lost this way does not advance the pointer.
- Leader:
  - LEAD<=argmax(Q) evaluated on the current registered Q, so it is one cycle behind Q.
  - Ties resolve to the lowest index; all-zero gives 0.
- Addend 0: commits normally and consumes the grant; Q is unchanged.

Decomposition:
- Package score_pkg holds:
  - a sat_add function (operands a, b, sat flag; returns {ovf, result});
  - the leader-width localparam helper.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs clk, CLR, req[N-1:0];
  - outputs gnt one-hot and gnt_idx;
  - contains the round-robin pointer.
- Per-channel buffer and score registers live in a generate loop in score_accumulator.

Test Plan:
1. Reset: CLR asserted mid-operation with pend_v=11 -> Q=0, OVF=0, DROP=0, RDY=11, LEAD=0 immediately; no commit after release.
2. Single channel: LD0 with D=1, three requests spaced 3 cycles apart -> Q0=1,2,3, each visible 1 cycle after capture; Q1 stays 0.
3. Simultaneous requests: LD=11, D0=5, D1=7 captured at edge k -> Q0=5 at k+1, Q1=7 at k+2; LEAD=1 at k+3; next simultaneous pair grants ch0 first again (pointer=1).
4. Overflow: WIDTH=8, Q0=250, add 10 -> Q0=255, OVF0=1 (SATURATE=1); with SATURATE=0 -> Q0=4, OVF0=1; OVF0 stays set after a further add of 1.
5. Backpressure: LD0 high on two consecutive cycles, D=3 -> second request dropped, DROP0=1, Q0=3.
6. Clear race: CLR_CH0=1 on the same edge ch0's pending D=9 would commit -> Q0=0, pend_v0=0, OVF0=0, DROP0=0; Q1 and pointer unaffected.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and helpers for the multi-channel score accumulator.
// sat_add works on operands up to MAX_W bits, so WIDTH must not exceed MAX_W.
package score_pkg;

   localparam int MAX_W = 32;

   // Width of a channel index; a two-channel design still needs one bit.
   function automatic int lead_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // Adds two w-bit values held in MAX_W-bit containers.
   // Returns {ovf, result}; ovf is the carry out of bit w-1.
   // When sat is set, an overflowing result clamps to all ones.
   // Otherwise it wraps modulo 2^w.
   function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b,
                                              input int               w,
                                              input logic             sat);
      logic [MAX_W:0] one;
      logic [MAX_W:0] mask;
      logic [MAX_W:0] sum;
      logic [MAX_W:0] res;
      logic           carry;
      one   = {{MAX_W{1'b0}}, 1'b1};
      mask  = (one << w) - one;
      sum   = {1'b0, a} + {1'b0, b};
      carry = |(sum & ~mask);
      res   = (carry && sat) ? mask : (sum & mask);
      return {carry, res[MAX_W-1:0]};
   endfunction

endpackage

// File: rtl/score_accumulator_rr_arbiter.sv
// Round-robin arbiter for the shared score adder.
// Each cycle the arbiter grants at most one requester.
// The search starts one past the last winner and wraps around.
// The pointer only moves when a grant is actually issued.
module rr_arbiter
   import score_pkg::*;
#(
   parameter int N = 2
)(
   input  logic                  clk,
   input  logic                  CLR,
   input  logic [N-1:0]          req,
   output logic [N-1:0]          gnt,
   output logic [lead_w(N)-1:0]  gnt_idx
);

   localparam int IW = lead_w(N);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic          anyGnt;
   int            slot;

   // Circular priority search starting at ptr_q+1; the first requester found wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      anyGnt  = 1'b0;
      slot    = 0;
      for (int k = 1; k <= N; k++) begin
         slot = int'(ptr_q) + k;
         if (slot >= N) begin
            slot = slot - N;
         end
         if (!anyGnt && req[slot]) begin
            anyGnt       = 1'b1;
            gnt[slot]    = 1'b1;
            gnt_idx      = IW'(slot);
         end
      end
      ptr_d = anyGnt ? gnt_idx : ptr_q;
   end

   // The pointer resets to the last index, which gives channel 0 first priority.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         ptr_q <= IW'(N - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/score_accumulator.sv
// Multi-channel score accumulator.
// Each channel holds one pending addend in a one-entry buffer.
// A single adder, granted round-robin, commits one pending addend per cycle.
// Overflow and dropped-request flags are sticky until CLR or CLR_CH.
// LEAD is the index of the highest score, taken from the previous cycle's Q.
module score_accumulator
   import score_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2,
   parameter bit SATURATE = 1'b1
)(
   input  logic                         clk,
   input  logic                         CLR,
   input  logic [CHANNELS-1:0]          LD,
   input  logic [CHANNELS*WIDTH-1:0]    D,
   input  logic [CHANNELS-1:0]          CLR_CH,
   output logic [CHANNELS-1:0]          RDY,
   output logic [CHANNELS*WIDTH-1:0]    Q,
   output logic [CHANNELS-1:0]          OVF,
   output logic [CHANNELS-1:0]          DROP,
   output logic [lead_w(CHANNELS)-1:0]  LEAD
);

   localparam int LW = lead_w(CHANNELS);

   logic [CHANNELS-1:0]       pendV;
   logic [CHANNELS*WIDTH-1:0] pendAll;
   logic [CHANNELS-1:0]       req;
   logic [CHANNELS-1:0]       gnt;
   logic [LW-1:0]             gntIdx;

   logic [WIDTH-1:0]          addA;
   logic [WIDTH-1:0]          addB;
   logic [WIDTH-1:0]          addSum;
   logic                      addOvf;
   logic [MAX_W:0]            addRes;

   logic [LW-1:0]             leadIdx_q;
   logic [LW-1:0]             leadIdx_d;
   logic [WIDTH-1:0]          leadBest;

   // A channel being cleared this cycle must not win the adder.
   // Masking it here also keeps the round-robin pointer where it was.
   assign req = pendV & ~CLR_CH;
   assign RDY = ~pendV;

   rr_arbiter #(
      .N(CHANNELS)
   ) u_arb (
      .clk     (clk),
      .CLR     (CLR),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gntIdx)
   );

   // Shared adder: select the granted channel's score and addend, then add once.
   always_comb begin
      addA = '0;
      addB = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (gntIdx == LW'(c)) begin
            addA = Q[c*WIDTH +: WIDTH];
            addB = pendAll[c*WIDTH +: WIDTH];
         end
      end
      addRes = sat_add(MAX_W'(addA), MAX_W'(addB), WIDTH, SATURATE);
      addOvf = addRes[MAX_W];
      addSum = addRes[WIDTH-1:0];
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] score_q;
      logic [WIDTH-1:0] score_d;
      logic [WIDTH-1:0] pend_q;
      logic [WIDTH-1:0] pend_d;
      logic             pendV_q;
      logic             pendV_d;
      logic             ovf_q;
      logic             ovf_d;
      logic             drop_q;
      logic             drop_d;

      // Channel next state: a clear beats a commit and a capture.
      // A commit always frees the buffer.
      // A new LD is captured only into an empty buffer; otherwise it is dropped.
      always_comb begin
         score_d = score_q;
         pend_d  = pend_q;
         pendV_d = pendV_q;
         ovf_d   = ovf_q;
         drop_d  = drop_q;
         if (CLR_CH[i]) begin
            score_d = '0;
            ovf_d   = 1'b0;
            drop_d  = 1'b0;
            pendV_d = 1'b0;
         end else begin
            if (gnt[i]) begin
               score_d = addSum;
               ovf_d   = ovf_q | addOvf;
               pendV_d = 1'b0;
            end
            if (LD[i]) begin
               if (pendV_q) begin
                  drop_d = 1'b1;
               end else begin
                  pend_d  = D[i*WIDTH +: WIDTH];
                  pendV_d = 1'b1;
               end
            end
         end
      end

      // Channel state registers; CLR discards any pending request immediately.
      always_ff @(posedge clk or posedge CLR) begin
         if (CLR) begin
            score_q <= '0;
            pend_q  <= '0;
            pendV_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= 1'b0;
         end else begin
            score_q <= score_d;
            pend_q  <= pend_d;
            pendV_q <= pendV_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
         end
      end

      assign Q[i*WIDTH +: WIDTH]       = score_q;
      assign pendAll[i*WIDTH +: WIDTH] = pend_q;
      assign pendV[i]                  = pendV_q;
      assign OVF[i]                    = ovf_q;
      assign DROP[i]                   = drop_q;
   end

   // Argmax over the registered scores.
   // Only a strictly greater score replaces the current leader, so ties keep the lowest index.
   always_comb begin
      leadIdx_d = '0;
      leadBest  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (Q[c*WIDTH +: WIDTH] > leadBest) begin
            leadBest  = Q[c*WIDTH +: WIDTH];
            leadIdx_d = LW'(c);
         end
      end
   end

   // The leader index is registered, so it trails Q by one cycle.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         leadIdx_q <= '0;
      end else begin
         leadIdx_q <= leadIdx_d;
      end
   end

   assign LEAD = leadIdx_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Self-checking bench for score_accumulator (WIDTH=8, CHANNELS=2).
// A saturating and a wrapping instance share the same stimulus.
// Each instance is compared every cycle against its own behavioural model.
module tb_score_accumulator;

   localparam int W    = 8;
   localparam int CH   = 2;
   localparam int MAXV = 255;

   logic            clk;
   logic            CLR;
   logic [CH-1:0]   ld;
   logic [CH-1:0]   clrCh;
   logic [CH*W-1:0] d;

   logic [CH-1:0]   rdyS, ovfS, dropS, rdyW, ovfW, dropW;
   logic [CH*W-1:0] qS, qW;
   logic [0:0]      leadS, leadW;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state, indexed [instance][channel]; instance 0 saturates, 1 wraps.
   int mScore [2][CH];
   int mPd    [2][CH];
   bit mOvf   [2][CH];
   bit mDrop  [2][CH];
   bit mPv    [2][CH];
   int mPtr   [2];
   int mLead  [2];

   typedef struct {
      logic [1:0] ld;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] clrch;
      logic [7:0] q0;
      logic [7:0] q1;
      logic [1:0] rdy;
      logic [1:0] ovf;
      logic [1:0] drop;
      logic       lead;
   } vec_t;

   vec_t vecs [17];

   score_accumulator #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b1)) dut (
      .clk(clk), .CLR(CLR), .LD(ld), .D(d), .CLR_CH(clrCh),
      .RDY(rdyS), .Q(qS), .OVF(ovfS), .DROP(dropS), .LEAD(leadS)
   );

   score_accumulator #(.WIDTH(W), .CHANNELS(CH), .SATURATE(1'b0)) dutWrap (
      .clk(clk), .CLR(CLR), .LD(ld), .D(d), .CLR_CH(clrCh),
      .RDY(rdyW), .Q(qW), .OVF(ovfW), .DROP(dropW), .LEAD(leadW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends even if something stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int n = 0; n < 2; n++) begin
         for (int c = 0; c < CH; c++) begin
            mScore[n][c] = 0;
            mPd[n][c]    = 0;
            mOvf[n][c]   = 1'b0;
            mDrop[n][c]  = 1'b0;
            mPv[n][c]    = 1'b0;
         end
         mPtr[n]  = CH - 1;
         mLead[n] = 0;
      end
   endtask

   // One clock edge of the behavioural model, using the inputs present at the edge.
   task automatic modelStep(input int n);
      int  best, newLead, g, s;
      bit  oldPv [CH];
      if (CLR) begin
         for (int c = 0; c < CH; c++) begin
            mScore[n][c] = 0;
            mPd[n][c]    = 0;
            mOvf[n][c]   = 1'b0;
            mDrop[n][c]  = 1'b0;
            mPv[n][c]    = 1'b0;
         end
         mPtr[n]  = CH - 1;
         mLead[n] = 0;
         return;
      end
      best    = 0;
      newLead = 0;
      for (int c = 0; c < CH; c++) begin
         if (mScore[n][c] > best) begin
            best    = mScore[n][c];
            newLead = c;
         end
      end
      g = -1;
      for (int k = 1; k <= CH; k++) begin
         int j;
         j = (mPtr[n] + k) % CH;
         if (g < 0 && mPv[n][j] && !clrCh[j]) g = j;
      end
      for (int c = 0; c < CH; c++) oldPv[c] = mPv[n][c];
      for (int c = 0; c < CH; c++) begin
         if (clrCh[c]) begin
            mScore[n][c] = 0;
            mOvf[n][c]   = 1'b0;
            mDrop[n][c]  = 1'b0;
            mPv[n][c]    = 1'b0;
         end else begin
            if (c == g) begin
               s = mScore[n][c] + mPd[n][c];
               if (s > MAXV) begin
                  mOvf[n][c]   = 1'b1;
                  mScore[n][c] = (n == 0) ? MAXV : s - (MAXV + 1);
               end else begin
                  mScore[n][c] = s;
               end
               mPv[n][c] = 1'b0;
            end
            if (ld[c]) begin
               if (oldPv[c]) begin
                  mDrop[n][c] = 1'b1;
               end else begin
                  mPv[n][c] = 1'b1;
                  mPd[n][c] = int'(d[c*W +: W]);
               end
            end
         end
      end
      if (g >= 0) mPtr[n] = g;
      mLead[n] = newLead;
   endtask

   task automatic checkModel(input int n, input logic [CH*W-1:0] q, input logic [CH-1:0] ovf,
                             input logic [CH-1:0] drop, input logic [CH-1:0] rdy, input logic [0:0] lead);
      for (int c = 0; c < CH; c++) begin
         checkVal($sformatf("model%0d_q%0d", n, c), 64'(q[c*W +: W]), 64'(mScore[n][c]));
         checkVal($sformatf("model%0d_ovf%0d", n, c), 64'(ovf[c]), 64'(mOvf[n][c]));
         checkVal($sformatf("model%0d_drop%0d", n, c), 64'(drop[c]), 64'(mDrop[n][c]));
         checkVal($sformatf("model%0d_rdy%0d", n, c), 64'(rdy[c]), 64'(!mPv[n][c]));
      end
      checkVal($sformatf("model%0d_lead", n), 64'(lead), 64'(mLead[n]));
   endtask

   task automatic applyStimulus(input logic [1:0] l, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [1:0] cc);
      ld    = l;
      d     = {d1, d0};
      clrCh = cc;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      #1;
      checkModel(0, qS, ovfS, dropS, rdyS, leadS);
      checkModel(1, qW, ovfW, dropW, rdyW, leadW);
   endtask

   task automatic checkOutput(input vec_t v, input int row);
      checkVal($sformatf("row%0d_q0", row), 64'(qS[7:0]), 64'(v.q0));
      checkVal($sformatf("row%0d_q1", row), 64'(qS[15:8]), 64'(v.q1));
      checkVal($sformatf("row%0d_rdy", row), 64'(rdyS), 64'(v.rdy));
      checkVal($sformatf("row%0d_ovf", row), 64'(ovfS), 64'(v.ovf));
      checkVal($sformatf("row%0d_drop", row), 64'(dropS), 64'(v.drop));
      checkVal($sformatf("row%0d_lead", row), 64'(leadS), 64'(v.lead));
   endtask

   initial begin
      //            ld     d0     d1     clr    q0     q1     rdy    ovf    drop   lead
      vecs[0]  = '{2'b11, 8'd5, 8'd7, 2'b00, 8'd0, 8'd0,  2'b00, 2'b00, 2'b00, 1'b0};
      vecs[1]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd5, 8'd0,  2'b01, 2'b00, 2'b00, 1'b0};
      vecs[2]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd5, 8'd7,  2'b11, 2'b00, 2'b00, 1'b0};
      vecs[3]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd5, 8'd7,  2'b11, 2'b00, 2'b00, 1'b1};
      vecs[4]  = '{2'b11, 8'd1, 8'd1, 2'b00, 8'd5, 8'd7,  2'b00, 2'b00, 2'b00, 1'b1};
      vecs[5]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd6, 8'd7,  2'b01, 2'b00, 2'b00, 1'b1};
      vecs[6]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd6, 8'd8,  2'b11, 2'b00, 2'b00, 1'b1};
      vecs[7]  = '{2'b01, 8'd3, 8'd0, 2'b00, 8'd6, 8'd8,  2'b10, 2'b00, 2'b00, 1'b1};
      vecs[8]  = '{2'b01, 8'd3, 8'd0, 2'b00, 8'd9, 8'd8,  2'b11, 2'b00, 2'b01, 1'b1};
      vecs[9]  = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd9, 8'd8,  2'b11, 2'b00, 2'b01, 1'b0};
      vecs[10] = '{2'b10, 8'd0, 8'd1, 2'b00, 8'd9, 8'd8,  2'b01, 2'b00, 2'b01, 1'b0};
      vecs[11] = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd9, 8'd9,  2'b11, 2'b00, 2'b01, 1'b0};
      vecs[12] = '{2'b01, 8'd9, 8'd0, 2'b00, 8'd9, 8'd9,  2'b10, 2'b00, 2'b01, 1'b0};
      vecs[13] = '{2'b00, 8'd0, 8'd0, 2'b01, 8'd0, 8'd9,  2'b11, 2'b00, 2'b00, 1'b0};
      vecs[14] = '{2'b11, 8'd1, 8'd1, 2'b00, 8'd0, 8'd9,  2'b00, 2'b00, 2'b00, 1'b1};
      vecs[15] = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd1, 8'd9,  2'b01, 2'b00, 2'b00, 1'b1};
      vecs[16] = '{2'b00, 8'd0, 8'd0, 2'b00, 8'd1, 8'd10, 2'b11, 2'b00, 2'b00, 1'b1};

      CLR = 1'b1;
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b00);
      modelReset();
      repeat (2) @(posedge clk);
      #1 CLR = 1'b0;

      $display("[TB] reset state");
      checkVal("reset_q", 64'(qS), 64'd0);
      checkVal("reset_rdy", 64'(rdyS), 64'd3);
      checkVal("reset_ovf", 64'(ovfS), 64'd0);
      checkVal("reset_drop", 64'(dropS), 64'd0);
      checkVal("reset_lead", 64'(leadS), 64'd0);

      $display("[TB] directed vector table");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].ld, vecs[i].d0, vecs[i].d1, vecs[i].clrch);
         tick();
         checkOutput(vecs[i], i);
      end

      $display("[TB] overflow sequence");
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b11);
      tick();
      applyStimulus(2'b01, 8'd250, 8'd0, 2'b00);
      tick();
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b00);
      tick();
      checkVal("ovf_sat_base", 64'(qS[7:0]), 64'd250);
      checkVal("ovf_wrap_base", 64'(qW[7:0]), 64'd250);
      applyStimulus(2'b01, 8'd10, 8'd0, 2'b00);
      tick();
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b00);
      tick();
      checkVal("ovf_sat_q", 64'(qS[7:0]), 64'd255);
      checkVal("ovf_sat_flag", 64'(ovfS[0]), 64'd1);
      checkVal("ovf_wrap_q", 64'(qW[7:0]), 64'd4);
      checkVal("ovf_wrap_flag", 64'(ovfW[0]), 64'd1);
      applyStimulus(2'b01, 8'd1, 8'd0, 2'b00);
      tick();
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b00);
      tick();
      checkVal("ovf_sat_sticky_q", 64'(qS[7:0]), 64'd255);
      checkVal("ovf_sat_sticky", 64'(ovfS[0]), 64'd1);
      checkVal("ovf_wrap_sticky_q", 64'(qW[7:0]), 64'd5);
      checkVal("ovf_wrap_sticky", 64'(ovfW[0]), 64'd1);

      $display("[TB] asynchronous reset with requests pending");
      applyStimulus(2'b11, 8'd3, 8'd3, 2'b00);
      tick();
      applyStimulus(2'b00, 8'd0, 8'd0, 2'b00);
      #3 CLR = 1'b1;
      #1;
      checkVal("areset_q", 64'(qS), 64'd0);
      checkVal("areset_rdy", 64'(rdyS), 64'd3);
      checkVal("areset_ovf", 64'(ovfS), 64'd0);
      checkVal("areset_drop", 64'(dropS), 64'd0);
      checkVal("areset_lead", 64'(leadS), 64'd0);
      checkVal("areset_wrap_q", 64'(qW), 64'd0);
      modelReset();
      tick();
      CLR = 1'b0;
      tick();
      tick();
      checkVal("areset_no_commit", 64'(qS), 64'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                       ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         CLR = ($urandom_range(0, 63) == 0);
         tick();
      end
      CLR = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
